// File: rtl/snd_cmd_sender.sv
// Main-CPU side of the sound command link: queues 68K sound codes and replays each one
// as an SNDDT latch strobe and then an SNDON IRQ strobe. It then waits for the Z80 ack or for a timeout.
module snd_cmd_sender #(
  parameter int DEPTH_LOG2  = 2,
  parameter int SETUP_CYC   = 4,
  parameter int PULSE_CYC   = 8,
  parameter int HOLD_CYC    = 4,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic                clk_main,
  input  logic                RESET,
  input  logic                cmd_wr,
  input  logic [7:0]          cmd_data,
  input  logic                z80_ack,
  input  logic                err_clr,
  output logic [7:0]          SND_D,
  output logic                SNDDT,
  output logic                SNDON,
  output logic                busy,
  output logic [DEPTH_LOG2:0] fifo_count,
  output logic                fifo_full,
  output logic                overflow,
  output logic                timeout_err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2 + 1)'(0);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  // Each state's counter is loaded with length-1, so the state lasts exactly its parameter.
  localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
  localparam logic [15:0] PULSE_LD = 16'(PULSE_CYC - 1);
  localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] ACK_LD   = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_DT_HI    = 3'd2,
    ST_DT_LO    = 3'd3,
    ST_ON_HI    = 3'd4,
    ST_WAIT_ACK = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic [15:0]           cnt, cnt_nxt;
  logic                  ack_flag, ack_flag_nxt;
  logic                  pop, push, ovf_set, timeout_set;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [7:0]            mem [DEPTH];

  // Sequencer next state, counter reload, pop request and ack capture.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = (cnt != 16'd0) ? (cnt - 16'd1) : 16'd0;
    ack_flag_nxt = ack_flag;
    pop          = 1'b0;
    timeout_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fifo_count != CNT_ZERO) begin
          pop          = 1'b1;
          ack_flag_nxt = 1'b0;
          state_nxt    = ST_SETUP;
          cnt_nxt      = SETUP_LD;
        end else begin
          cnt_nxt      = 16'd0;
        end
      end
      ST_SETUP: begin
        if (cnt == 16'd0) begin
          state_nxt = ST_DT_HI;
          cnt_nxt   = PULSE_LD;
        end else begin
          state_nxt = ST_SETUP;
        end
      end
      ST_DT_HI: begin
        if (cnt == 16'd0) begin
          state_nxt = ST_DT_LO;
          cnt_nxt   = HOLD_LD;
        end else begin
          state_nxt = ST_DT_HI;
        end
      end
      ST_DT_LO: begin
        if (cnt == 16'd0) begin
          state_nxt = ST_ON_HI;
          cnt_nxt   = PULSE_LD;
        end else begin
          state_nxt = ST_DT_LO;
        end
      end
      ST_ON_HI: begin
        // An early ack is remembered so WAIT_ACK can leave after a single cycle.
        if (z80_ack) begin
          ack_flag_nxt = 1'b1;
        end else begin
          ack_flag_nxt = ack_flag;
        end
        if (cnt == 16'd0) begin
          state_nxt = ST_WAIT_ACK;
          cnt_nxt   = ACK_LD;
        end else begin
          state_nxt = ST_ON_HI;
        end
      end
      ST_WAIT_ACK: begin
        if (z80_ack || ack_flag) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 16'd0;
        end else if (cnt == 16'd0) begin
          state_nxt   = ST_IDLE;
          timeout_set = 1'b1;
        end else begin
          state_nxt = ST_WAIT_ACK;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 16'd0;
      end
    endcase
  end

  // FIFO push acceptance and occupancy update; a pop frees a slot for a push while full.
  always_comb begin
    push    = cmd_wr & (~fifo_full | pop);
    ovf_set = cmd_wr & fifo_full & ~pop;
    case ({push, pop})
      2'b10:   count_nxt = fifo_count + CNT_ONE;
      2'b01:   count_nxt = fifo_count - CNT_ONE;
      default: count_nxt = fifo_count;
    endcase
  end

  // FIFO storage, written on accepted pushes.
  always_ff @(posedge clk_main) begin
    if (push) begin
      mem[wr_ptr] <= cmd_data;
    end
  end

  // State, counters, pointers, sticky flags and registered strobes.
  always_ff @(posedge clk_main) begin
    if (RESET) begin
      state       <= ST_IDLE;
      cnt         <= 16'd0;
      ack_flag    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= CNT_ZERO;
      fifo_full   <= 1'b0;
      SND_D       <= 8'h00;
      SNDDT       <= 1'b0;
      SNDON       <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ack_flag    <= ack_flag_nxt;
      fifo_count  <= count_nxt;
      fifo_full   <= (count_nxt == CNT_FULL);
      SNDDT       <= (state_nxt == ST_DT_HI);
      SNDON       <= (state_nxt == ST_ON_HI);
      busy        <= (state_nxt != ST_IDLE);
      overflow    <= ovf_set | (overflow & ~err_clr);
      timeout_err <= timeout_set | (timeout_err & ~err_clr);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        SND_D  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_snd_cmd_sender.sv
// Self-checking bench for snd_cmd_sender: directed scenarios plus random codes and ack timing.
// The receiver-side observer logs strobe edges and checks them against the link timing rules.
module tb_snd_cmd_sender;

  localparam int DL2   = 2;
  localparam int DEPTH = 4;
  localparam int SETUP = 4;
  localparam int PULSE = 8;
  localparam int HOLD  = 4;
  localparam int TMO   = 4096;

  logic       clk_main = 1'b0;
  logic       RESET, cmd_wr, z80_ack, err_clr;
  logic [7:0] cmd_data;
  logic [7:0] SND_D;
  logic       SNDDT, SNDON, busy, fifo_full, overflow, timeout_err;
  logic [2:0] fifo_count;

  snd_cmd_sender #(
    .DEPTH_LOG2(DL2), .SETUP_CYC(SETUP), .PULSE_CYC(PULSE),
    .HOLD_CYC(HOLD), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk_main(clk_main), .RESET(RESET), .cmd_wr(cmd_wr), .cmd_data(cmd_data),
    .z80_ack(z80_ack), .err_clr(err_clr), .SND_D(SND_D), .SNDDT(SNDDT),
    .SNDON(SNDON), .busy(busy), .fifo_count(fifo_count), .fifo_full(fifo_full),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk_main = ~clk_main;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Observed events (sample indices) and the receiver's latched codes.
  int busy_rise_q[$], busy_fall_q[$], dt_rise_q[$], dt_fall_q[$];
  int on_rise_q[$], on_fall_q[$], rx_q[$];
  // Expectations built by the bench.
  int exp_codes[$], exp_wait_q[$], mode_q[$];
  int overlap_cnt, unstable_cnt, cur_mode, fix_delay, ack_at, errclr_at;
  bit clr_race, locked;
  logic       p_busy, p_dt, p_on;
  logic [7:0] p_d, lock_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -100000;
  endfunction

  task automatic clear_log();
    busy_rise_q.delete(); busy_fall_q.delete(); dt_rise_q.delete(); dt_fall_q.delete();
    on_rise_q.delete(); on_fall_q.delete(); rx_q.delete();
    exp_codes.delete(); exp_wait_q.delete(); mode_q.delete();
    overlap_cnt = 0; unstable_cnt = 0; cur_mode = 1; fix_delay = -1;
    ack_at = -1; errclr_at = -1; clr_race = 1'b0;
  endtask

  // Receiver model and ack planner: ack modes 0 = never, 1 = during ON_HI, 2 = during WAIT_ACK.
  task automatic observe();
    int d;
    if (RESET) begin
      p_busy = busy; p_dt = SNDDT; p_on = SNDON; p_d = SND_D; locked = 1'b0;
      return;
    end
    if (SNDDT && SNDON) overlap_cnt++;
    if (busy && !p_busy) begin
      busy_rise_q.push_back(cyc);
      lock_val = SND_D;
      locked   = 1'b1;
    end else if (locked && SND_D !== lock_val) begin
      unstable_cnt++;
    end
    if (!busy && SND_D !== p_d) unstable_cnt++;
    if (!busy && p_busy) busy_fall_q.push_back(cyc);
    if (SNDDT && !p_dt) begin
      dt_rise_q.push_back(cyc);
      rx_q.push_back(int'(SND_D));
    end
    if (!SNDDT && p_dt) dt_fall_q.push_back(cyc);
    if (SNDON && !p_on) begin
      on_rise_q.push_back(cyc);
      locked   = 1'b0;
      cur_mode = (mode_q.size() > 0) ? mode_q.pop_front() : int'($urandom_range(1, 2));
      if (cur_mode == 1) begin
        d = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, PULSE - 1));
        ack_at = cyc + d;
        exp_wait_q.push_back(1);
      end else if (cur_mode == 0) begin
        exp_wait_q.push_back(TMO);
        if (clr_race) errclr_at = cyc + PULSE + TMO - 1;
      end
    end
    if (!SNDON && p_on) begin
      on_fall_q.push_back(cyc);
      if (cur_mode == 2) begin
        d = int'($urandom_range(0, 12));
        ack_at = cyc + d;
        exp_wait_q.push_back(d + 1);
      end
    end
    p_busy = busy; p_dt = SNDDT; p_on = SNDON; p_d = SND_D;
  endtask

  // One clock: sample #1 after the edge, then drive inputs for the next edge.
  // Stray acks while SNDDT is high must be ignored by the sender.
  task automatic step();
    @(posedge clk_main);
    #1;
    cyc++;
    observe();
    cmd_wr  = 1'b0;
    z80_ack = (cyc == ack_at) || (SNDDT && ($urandom_range(0, 2) == 0));
    err_clr = (cyc == errclr_at);
  endtask

  task automatic push(input logic [7:0] code);
    cmd_wr   = 1'b1;
    cmd_data = code;
    step();
  endtask

  task automatic do_clr();
    err_clr = 1'b1;
    step();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(!busy && fifo_count == 3'd0) && n < budget) begin
      step();
      n++;
    end
    chk("idle_within_budget", (n < budget), 1);
  endtask

  task automatic check_transfers(input bit b2b);
    chk("n_codes_latched", rx_q.size(), exp_codes.size());
    chk("n_sndon_pulses", on_rise_q.size(), exp_codes.size());
    for (int i = 0; i < exp_codes.size(); i++) begin
      chk($sformatf("code[%0d]", i), qget(rx_q, i), exp_codes[i]);
      chk($sformatf("setup[%0d]", i), qget(dt_rise_q, i) - qget(busy_rise_q, i), SETUP);
      chk($sformatf("dt_width[%0d]", i), qget(dt_fall_q, i) - qget(dt_rise_q, i), PULSE);
      chk($sformatf("hold[%0d]", i), qget(on_rise_q, i) - qget(dt_fall_q, i), HOLD);
      chk($sformatf("on_width[%0d]", i), qget(on_fall_q, i) - qget(on_rise_q, i), PULSE);
      chk($sformatf("wait[%0d]", i), qget(busy_fall_q, i) - qget(on_fall_q, i),
          qget(exp_wait_q, i));
      if (b2b && i > 0)
        chk($sformatf("idle_gap[%0d]", i), qget(busy_rise_q, i) - qget(busy_fall_q, i - 1), 1);
    end
    chk("strobe_overlap", overlap_cnt, 0);
    chk("snd_d_unstable", unstable_cnt, 0);
  endtask

  initial begin
    logic [7:0] c;
    clear_log();
    RESET = 1'b1; cmd_wr = 1'b0; cmd_data = 8'h00; z80_ack = 1'b0; err_clr = 1'b0;
    repeat (3) step();
    chk("rst_SND_D", SND_D, 8'h00);
    chk("rst_SNDDT", SNDDT, 1'b0);
    chk("rst_SNDON", SNDON, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fifo_count", fifo_count, 3'd0);
    chk("rst_fifo_full", fifo_full, 1'b0);
    chk("rst_flags", {overflow, timeout_err}, 2'b00);
    RESET = 1'b0;
    step();

    // Single code with an ack three cycles into SNDON.
    clear_log();
    mode_q.push_back(1); fix_delay = 3;
    exp_codes.push_back(8'h5A);
    push(8'h5A);
    wait_idle(200);
    check_transfers(1'b0);
    chk("t1_timeout_err", timeout_err, 1'b0);

    // Five pushes while busy: the fifth overflows and is never sent.
    clear_log();
    exp_codes.push_back(8'h77);
    push(8'h77);
    step(); step();
    for (int k = 1; k <= 5; k++) begin
      c = 8'(k);
      push(c);
      if (k <= DEPTH) exp_codes.push_back(k);
      chk($sformatf("t2_count_after_%0d", k), fifo_count, (k <= DEPTH) ? k : DEPTH);
      chk($sformatf("t2_overflow_after_%0d", k), overflow, (k > DEPTH));
    end
    chk("t2_full", fifo_full, 1'b1);
    wait_idle(400);
    check_transfers(1'b1);
    chk("t2_overflow_sticky", overflow, 1'b1);
    do_clr();
    chk("t2_overflow_cleared", overflow, 1'b0);

    // No ack: full timeout, err_clr on the expiry cycle loses, next code follows.
    clear_log();
    mode_q.push_back(0); mode_q.push_back(1); clr_race = 1'b1;
    for (int k = 0; k < 2; k++) begin
      c = 8'($urandom_range(0, 255));
      exp_codes.push_back(c);
      push(c);
    end
    wait_idle(TMO + 300);
    check_transfers(1'b1);
    chk("t3_timeout_err", timeout_err, 1'b1);
    do_clr();
    chk("t3_timeout_cleared", timeout_err, 1'b0);

    // Ack during ON_HI at a random point.
    clear_log();
    mode_q.push_back(1);
    c = 8'($urandom_range(0, 255));
    exp_codes.push_back(c);
    push(c);
    wait_idle(200);
    check_transfers(1'b0);
    chk("t4_timeout_err", timeout_err, 1'b0);

    // Push coinciding with the IDLE pop while full is accepted without overflow.
    clear_log();
    exp_codes.push_back(8'h33);
    push(8'h33);
    step(); step();
    for (int k = 0; k < DEPTH; k++) begin
      c = 8'($urandom_range(0, 255));
      exp_codes.push_back(c);
      push(c);
    end
    for (int k = 0; k < 300 && busy; k++) step();
    chk("t5_idle_seen", busy, 1'b0);
    c = 8'($urandom_range(0, 255));
    exp_codes.push_back(c);
    push(c);
    chk("t5_count", fifo_count, 3'd4);
    chk("t5_overflow", overflow, 1'b0);
    chk("t5_full", fifo_full, 1'b1);
    wait_idle(600);
    check_transfers(1'b1);

    // Random codes at random spacing with random ack timing.
    clear_log();
    for (int k = 0; k < 8; k++) begin
      c = 8'($urandom_range(0, 255));
      exp_codes.push_back(c);
      push(c);
      repeat ($urandom_range(20, 60)) step();
    end
    wait_idle(600);
    check_transfers(1'b0);
    chk("t7_flags", {overflow, timeout_err}, 2'b00);

    // Reset during DT_HI aborts the transfer: no SNDON, FIFO flushed.
    clear_log();
    c = 8'($urandom_range(0, 255));
    push(c);
    push(8'hA1);
    push(8'hA2);
    for (int k = 0; k < 20 && !SNDDT; k++) step();
    chk("t6_dt_seen", SNDDT, 1'b1);
    step(); step();
    RESET = 1'b1;
    step();
    chk("t6_SNDDT", SNDDT, 1'b0);
    chk("t6_fifo_count", fifo_count, 3'd0);
    chk("t6_busy", busy, 1'b0);
    RESET = 1'b0;
    repeat (100) step();
    chk("t6_no_sndon", on_rise_q.size(), 0);
    chk("t6_one_latch", rx_q.size(), 1);
    chk("t6_latched_code", qget(rx_q, 0), c);
    chk("t6_still_idle", {busy, SNDDT, SNDON}, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
